// File: rtl/saa_opt_pkg.sv
// Shared definitions for the saa_opt systolic-array matrix-multiply block:
// FSM state encoding, default geometry and phase-length helpers.
package saa_opt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    STORE   = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int N_DEF  = 5;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 8;

  // LOAD: N^2 words of A, N^2 words of B, plus one cycle of read latency.
  function automatic int load_len(input int n);
    return 2 * n * n + 1;
  endfunction

  // COMPUTE: skewed wavefront needs 3N-2 cycles to reach PE(N-1,N-1).
  function automatic int compute_len(input int n);
    return 3 * n - 2;
  endfunction

  // STORE: one result word per cycle.
  function automatic int store_len(input int n);
    return n * n;
  endfunction

endpackage

// File: rtl/saa_opt_pe.sv
// saa_opt_pe: one output-stationary MAC cell. Operands entering from the left
// (a) and top (b) are registered and forwarded right/down; the accumulator
// keeps acc += a*b modulo 2^DW.
// Optional build macro SAA_OPT_SIGNED_EN: operands and accumulator are
// treated as two's-complement signed values.
module saa_opt_pe
  import saa_opt_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic [DW-1:0] acc_o
);

  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] acc_q, acc_d;

  // Multiply-accumulate with the product truncated to DW bits before the add.
  function automatic logic [DW-1:0] mac_trunc(input logic [DW-1:0] acc,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
`ifdef SAA_OPT_SIGNED_EN
    logic signed [DW-1:0] prod;
    logic signed [DW-1:0] acc_s;
    acc_s = $signed(acc);
    prod  = DW'($signed(a) * $signed(b));
    return DW'(acc_s + prod);
`else
    logic [DW-1:0] prod;
    prod = DW'(a * b);
    return acc + prod;
`endif
  endfunction

  // Next state: clear wins, otherwise forward operands and accumulate when enabled.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (clr_i) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (en_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = mac_trunc(acc_q, a_i, b_i);
    end
  end

  // Operand forwarding registers and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/saa_opt.sv
// saa_opt: N x N output-stationary systolic matrix multiplier with a private
// 2^AW-word memory. On init it loads A and B, computes C = A*B, stores C
// row-major at the latched C base and then holds complete high.
// Optional build macro SAA_OPT_SIGNED_EN (used inside saa_opt_pe) selects
// signed arithmetic; the default build is unsigned.
module saa_opt
  import saa_opt_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  output logic          complete,
  input  logic [AW-1:0] base_address_A,
  input  logic [AW-1:0] base_address_B,
  input  logic [AW-1:0] base_address_C
);

  localparam int NN    = N * N;
  localparam int CW    = $clog2(2 * NN + 1);
  localparam int AB_IW = $clog2(2 * NN);
  localparam int C_IW  = $clog2(NN);

  localparam logic [CW-1:0] LOAD_LAST    = CW'(load_len(N) - 1);
  localparam logic [CW-1:0] COMPUTE_LAST = CW'(compute_len(N) - 1);
  localparam logic [CW-1:0] STORE_LAST   = CW'(store_len(N) - 1);
  localparam logic [CW-1:0] NN_C         = CW'(NN);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          complete_q;
  logic [AW-1:0] base_a_q, base_b_q, base_c_q;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] ab_rf [2*NN];

  logic          start_d;
  logic          pe_clr_d;
  logic          pe_en_d;
  logic [AW-1:0] rd_addr_d;
  logic [AW-1:0] wr_addr_d;
  logic          wr_en_d;
  logic [DW-1:0] wr_data_d;

  logic [DW-1:0] feed_a_d [N];
  logic [DW-1:0] feed_b_d [N];
  logic [DW-1:0] a_link   [N][N+1];
  logic [DW-1:0] b_link   [N+1][N];
  logic [DW-1:0] acc_w    [NN];

  // A run is accepted from IDLE or as a restart from DONE; elsewhere init is ignored.
  always_comb begin
    start_d  = init && ((state_q == IDLE) || (state_q == DONE));
    pe_clr_d = (state_q == IDLE) || start_d;
    pe_en_d  = (state_q == COMPUTE);
  end

  // Sequencer: phase FSM, shared phase counter, latched bases and complete flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      complete_q <= 1'b0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      base_c_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_d) begin
            state_q  <= LOAD;
            base_a_q <= base_address_A;
            base_b_q <= base_address_B;
            base_c_q <= base_address_C;
          end
        end
        LOAD: begin
          if (cnt_q == LOAD_LAST) begin
            state_q <= COMPUTE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        COMPUTE: begin
          if (cnt_q == COMPUTE_LAST) begin
            state_q <= STORE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STORE: begin
          if (cnt_q == STORE_LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (start_d) begin
            state_q    <= LOAD;
            complete_q <= 1'b0;
            cnt_q      <= '0;
            base_a_q   <= base_address_A;
            base_b_q   <= base_address_B;
            base_c_q   <= base_address_C;
          end else begin
            complete_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          complete_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory port addressing: A words then B words on read, C row-major on write.
  always_comb begin
    if (cnt_q >= NN_C) rd_addr_d = base_b_q + AW'(cnt_q - NN_C);
    else               rd_addr_d = base_a_q + AW'(cnt_q);
    wr_en_d   = (state_q == STORE);
    wr_addr_d = base_c_q + AW'(cnt_q);
    wr_data_d = acc_w[C_IW'(cnt_q)];
  end

  // Data memory: synchronous write, synchronous 1-cycle read; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_d) mem[wr_addr_d] <= wr_data_d;
    rdata_q <= mem[rd_addr_d];
  end

  // Operand register file: word k read at LOAD count k lands here one cycle later.
  always_ff @(posedge clk) begin
    if ((state_q == LOAD) && (cnt_q != '0)) begin
      ab_rf[AB_IW'(cnt_q - CW'(1))] <= rdata_q;
    end
  end

  // Skewed edge feeds: row i sees A[i][t-i], column j sees B[t-j][j], zero outside.
  always_comb begin
    int k;
    k = 0;
    for (int i = 0; i < N; i++) begin
      feed_a_d[i] = '0;
      feed_b_d[i] = '0;
      if (state_q == COMPUTE) begin
        k = int'(cnt_q) - i;
        if ((k >= 0) && (k < N)) begin
          feed_a_d[i] = ab_rf[AB_IW'(i * N + k)];
          feed_b_d[i] = ab_rf[AB_IW'(NN + k * N + i)];
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    assign a_link[i][0] = feed_a_d[i];
    assign b_link[0][i] = feed_b_d[i];

    // Operands leaving the far edge of the array are not consumed.
    logic [DW-1:0] edge_unused;
    assign edge_unused = a_link[i][N] ^ b_link[N][i];

    for (genvar j = 0; j < N; j++) begin : g_col
      saa_opt_pe #(
        .DW(DW)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr_i (pe_clr_d),
        .en_i  (pe_en_d),
        .a_i   (a_link[i][j]),
        .b_i   (b_link[i][j]),
        .a_o   (a_link[i][j+1]),
        .b_o   (b_link[i+1][j]),
        .acc_o (acc_w[i*N+j])
      );
    end
  end

  assign complete = complete_q;

endmodule

// File: tb/tb_saa_opt.sv
// Self-checking bench for saa_opt: randomized memory images checked against a
// plain matrix-product reference computed from a pre-run memory snapshot.
module tb_saa_opt;
  import saa_opt_pkg::*;

  logic       clk;
  logic       rst;
  logic       init;
  logic       complete;
  logic [7:0] base_a, base_b, base_c;

  int n_checks;
  int n_pass;

  logic [15:0] snap [256];
  logic [15:0] expm [256];

  saa_opt dut (
    .clk            (clk),
    .rst            (rst),
    .init           (init),
    .complete       (complete),
    .base_address_A (base_a),
    .base_address_B (base_b),
    .base_address_C (base_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fill_random();
    for (int a = 0; a < 256; a++) dut.mem[8'(a)] = 16'($urandom);
  endtask

  task automatic put_rand_mat(input logic [7:0] base);
    for (int x = 0; x < 25; x++) dut.mem[8'(int'(base) + x)] = 16'($urandom);
  endtask

  task automatic take_snapshot();
    for (int a = 0; a < 256; a++) snap[a] = dut.mem[8'(a)];
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j] mod 2^16, all operands from the snapshot.
  task automatic model(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bc);
    logic [15:0] c [25];
    logic [15:0] s;
    logic [7:0]  ai, bi;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        s = 16'd0;
        for (int k = 0; k < 5; k++) begin
          ai = 8'(int'(ba) + i * 5 + k);
          bi = 8'(int'(bb) + k * 5 + j);
          s  = 16'(s + snap[ai] * snap[bi]);
        end
        c[i*5+j] = s;
      end
    end
    for (int a = 0; a < 256; a++) expm[a] = snap[a];
    for (int x = 0; x < 25; x++) expm[8'(int'(bc) + x)] = c[x];
  endtask

  // Drive init for exactly one rising edge (that edge is edge 0 of the run).
  task automatic start_run(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bc);
    @(negedge clk);
    base_a = ba;
    base_b = bb;
    base_c = bc;
    init   = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
  endtask

  // Advance edge by edge from edge from_e; report the first edge where complete is seen high.
  task automatic wait_done(input int from_e, output int at_e);
    at_e = -1;
    for (int e = from_e; e <= 250; e++) begin
      @(posedge clk);
      #1;
      if (complete === 1'b1) begin
        at_e = e;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    init = 1'b0;
    base_a = 8'd0; base_b = 8'd0; base_c = 8'd0;
    fill_random();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (complete !== 1'b0) $display("FAIL reset_complete got %0b want 0", complete);
    else n_pass++;
    n_checks++;
    if (dut.state_q !== IDLE) $display("FAIL reset_state got %0d want %0d", int'(dut.state_q), int'(IDLE));
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (complete !== 1'b0 || dut.state_q !== IDLE)
      $display("FAIL idle_hold got complete=%0b state=%0d want 0/%0d", complete, int'(dut.state_q), int'(IDLE));
    else n_pass++;
  endtask

  task automatic test_identity();
    int at;
    fill_random();
    for (int x = 0; x < 25; x++) begin
      dut.mem[8'(x)]      = ((x / 5) == (x % 5)) ? 16'd1 : 16'd0;
      dut.mem[8'(25 + x)] = 16'(x + 1);
    end
    take_snapshot();
    model(8'd0, 8'd25, 8'd50);
    start_run(8'd0, 8'd25, 8'd50);
    wait_done(1, at);
    n_checks++;
    if (at != 90) $display("FAIL identity_latency got edge %0d want 90", at);
    else n_pass++;
    for (int x = 0; x < 25; x++) begin
      n_checks++;
      if (dut.mem[8'(50 + x)] !== 16'(x + 1))
        $display("FAIL identity_c addr %0d got %0d want %0d", 50 + x, dut.mem[8'(50 + x)], x + 1);
      else n_pass++;
    end
    for (int a = 0; a < 256; a++) begin
      n_checks++;
      if (dut.mem[8'(a)] !== expm[a])
        $display("FAIL identity_mem addr %0d got %0h want %0h", a, dut.mem[8'(a)], expm[a]);
      else n_pass++;
    end
  endtask

  task automatic test_const_fill(input logic [15:0] v, input logic [15:0] want);
    int at;
    fill_random();
    for (int x = 0; x < 25; x++) begin
      dut.mem[8'(100 + x)] = v;
      dut.mem[8'(150 + x)] = v;
    end
    start_run(8'd100, 8'd150, 8'd200);
    wait_done(1, at);
    n_checks++;
    if (at != 90) $display("FAIL const_latency got edge %0d want 90", at);
    else n_pass++;
    for (int x = 0; x < 25; x++) begin
      n_checks++;
      if (dut.mem[8'(200 + x)] !== want)
        $display("FAIL const_c v=%0d addr %0d got %0d want %0d", v, 200 + x, dut.mem[8'(200 + x)], want);
      else n_pass++;
    end
  endtask

  task automatic test_random(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bc);
    int at;
    fill_random();
    take_snapshot();
    model(ba, bb, bc);
    start_run(ba, bb, bc);
    wait_done(1, at);
    n_checks++;
    if (at != 90) $display("FAIL random_latency got edge %0d want 90", at);
    else n_pass++;
    for (int a = 0; a < 256; a++) begin
      n_checks++;
      if (dut.mem[8'(a)] !== expm[a])
        $display("FAIL random_mem bases %0h/%0h/%0h addr %0d got %0h want %0h", ba, bb, bc, a, dut.mem[8'(a)], expm[a]);
      else n_pass++;
    end
  endtask

  task automatic test_busy_restart();
    int at;
    fill_random();
    put_rand_mat(8'd100);
    put_rand_mat(8'd130);
    take_snapshot();
    model(8'd100, 8'd130, 8'd160);
    start_run(8'd100, 8'd130, 8'd160);
    for (int e = 1; e <= 29; e++) begin
      @(posedge clk);
      #1;
    end
    init   = 1'b1;
    base_a = 8'd7; base_b = 8'd9; base_c = 8'd11;
    @(posedge clk);
    #1;
    init = 1'b0;
    wait_done(31, at);
    n_checks++;
    if (at != 90) $display("FAIL busy_latency got edge %0d want 90", at);
    else n_pass++;
    for (int a = 0; a < 256; a++) begin
      n_checks++;
      if (dut.mem[8'(a)] !== expm[a])
        $display("FAIL busy_mem addr %0d got %0h want %0h", a, dut.mem[8'(a)], expm[a]);
      else n_pass++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (complete !== 1'b1) $display("FAIL done_hold got %0b want 1", complete);
    else n_pass++;
    put_rand_mat(8'd130);
    take_snapshot();
    model(8'd100, 8'd130, 8'd160);
    start_run(8'd100, 8'd130, 8'd160);
    n_checks++;
    if (complete !== 1'b0) $display("FAIL restart_drop got %0b want 0", complete);
    else n_pass++;
    wait_done(1, at);
    n_checks++;
    if (at != 90) $display("FAIL restart_latency got edge %0d want 90", at);
    else n_pass++;
    for (int a = 0; a < 256; a++) begin
      n_checks++;
      if (dut.mem[8'(a)] !== expm[a])
        $display("FAIL restart_mem addr %0d got %0h want %0h", a, dut.mem[8'(a)], expm[a]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int at;
    fill_random();
    start_run(8'd3, 8'd40, 8'd90);
    for (int e = 1; e <= 55; e++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut.state_q !== IDLE || complete !== 1'b0)
      $display("FAIL mid_reset got state=%0d complete=%0b want %0d/0", int'(dut.state_q), complete, int'(IDLE));
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    fill_random();
    take_snapshot();
    model(8'd3, 8'd40, 8'd90);
    start_run(8'd3, 8'd40, 8'd90);
    wait_done(1, at);
    n_checks++;
    if (at != 90) $display("FAIL post_reset_latency got edge %0d want 90", at);
    else n_pass++;
    for (int a = 0; a < 256; a++) begin
      n_checks++;
      if (dut.mem[8'(a)] !== expm[a])
        $display("FAIL post_reset_mem addr %0d got %0h want %0h", a, dut.mem[8'(a)], expm[a]);
      else n_pass++;
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (complete !== 1'b0) $display("FAIL done_async_reset got %0b want 0", complete);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_store();
    logic [7:0] ca;
    fill_random();
    take_snapshot();
    model(8'd10, 8'd60, 8'd120);
    start_run(8'd10, 8'd60, 8'd120);
    for (int e = 1; e <= 70; e++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    // Edges 65..70 stored C words 0..5; the rest of C keeps its old contents.
    for (int x = 6; x < 25; x++) begin
      ca = 8'(120 + x);
      expm[ca] = snap[ca];
    end
    for (int a = 0; a < 256; a++) begin
      n_checks++;
      if (dut.mem[8'(a)] !== expm[a])
        $display("FAIL store_reset_mem addr %0d got %0h want %0h", a, dut.mem[8'(a)], expm[a]);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_identity();
    test_const_fill(16'd1, 16'd5);
    test_const_fill(16'd300, 16'd56784);
    test_random(8'h20, 8'h60, 8'hF0);
    test_random(8'(12), 8'(20), 8'(15));
    for (int r = 0; r < 3; r++)
      test_random(8'($urandom), 8'($urandom), 8'($urandom));
    test_busy_restart();
    test_reset_mid();
    test_reset_store();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
